inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Instruction encoder: packs operands (format, register indices, funct fields, 32-bit signed immediate) into a 32-bit RV32I instruction word.
- Checks the immediate's range and alignment against the selected format.
- Two-stage valid/ready pipeline; tags each emitted word with a word-aligned instruction-memory write address from an internal counter.
- Used by the test/boot program loader to fill instruction memory, so it must produce exactly the immediate layouts the core decodes.

Parameters:
- ADDR_W, 32: width of the out_addr counter.
- BASE_ADDR, 0: address of the first emitted word and the value after reset/clear; must be a multiple of 4.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous: resets address counter to BASE_ADDR and flushes both stages.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- fmt  in  3  enc_pkg::fmt_e: R=0, I_LOAD=1, I_ALU=2, S=3, B=4, JALR=5, JAL=6; 7 is illegal.
- rd, rs1, rs2  in  5 each  register indices.
- funct3  in  3; funct7  in  7.
- imm  in  32  signed immediate (byte offset for B/JAL).
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts the word.
- out_inst  out  32  encoded instruction.
- out_addr  out  ADDR_W  write address for out_inst.
- out_err  out  1  immediate out of range, misaligned, or illegal fmt.

Behaviour:
- Reset (rst_n=0, async): s1_valid=s2_valid=0, out_valid=0, out_inst=0, out_err=0, out_addr=BASE_ADDR, in_ready=1 from the first cycle after release. A reset mid-operation drops all in-flight words.
- Stage 1 registers the bundle and computes the error flag.
- Stage 2 registers the packed word and the error flag. out_* are driven from stage 2.
- Latency: accept at cycle N gives out_valid=1 at N+2 when there is no backpressure. Throughput is 1 word/cycle.
- Handshake:
  - Transfer occurs on valid&&ready at the clock edge.
  - s2 loads when !s2_valid || out_ready. s1 loads when !s1_valid || s1 advances into s2.
  - in_ready = !s1_valid || (!s2_valid || out_ready). It is combinational from out_ready; no path from in_valid to in_ready.
  - While out_valid=1 and out_ready=0, out_inst, out_addr and out_err hold stable.
- Opcodes: R 0110011, I_LOAD 0000011, I_ALU 0010011, S 0100011, B 1100011, JALR 1100111 (funct3 forced 000), JAL 1101111.
- Field placement follows the RV32I base formats: rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25]. Unused fields are zero; rs2 is ignored for I-type; imm is ignored for R.
- Range rules:
  - I/S/JALR: imm[31:11] all equal (−2048..2047).
  - B: imm[31:12] all equal and imm[0]=0.
  - JAL: imm[31:20] all equal and imm[0]=0.
  - R: never errors.
  - fmt=7 always errors.
- On error: out_inst=32'h0000_0013 (NOP) with out_err=1. The word is still emitted and still consumes an address.
- Address: out_addr is the counter value. The counter increments by 4 on each output handshake and wraps modulo 2^ADDR_W.
- clear has priority over a simultaneous handshake: the word presented that cycle is dropped and out_valid=0 next cycle.

Optional Feature:
- Macro INST_ENC_ROUNDTRIP_CHK_EN.
- When defined: stage 2 feeds out_inst into an instance of the core immediate generator (imm_Gen). For B/I/S/JALR/JAL words with out_err=0, a decoded immediate ≠ the stage-2 copy of imm is a mismatch.
- On mismatch: sticky output rt_mismatch is set (cleared only by reset or clear), plus a simulation assertion.
- When undefined: no rt_mismatch port and no extra logic.

Decomposition:
- enc_pkg holds:
  - fmt_e enum
  - the seven opcode localparams
  - NOP constant 32'h0000_0013
  - function imm_fits(fmt, imm)
- Sub-module enc_pack, purely combinational: fmt/fields/imm → 32-bit word.
- The pipeline, handshake and address counter live in inst_encoder.

Test Plan:
- I_ALU, rd=1, rs1=0, funct3=0, imm=32'hFFFF_FFFF → out_inst=32'hFFF0_0093, out_err=0, out_addr=BASE_ADDR, 2 cycles after accept.
- S, rs1=3, rs2=2, funct3=2, imm=8 → 32'h0021_A423. Followed back-to-back by B, rs1=rs2=0, funct3=0, imm=−4 → 32'hFE00_0EE3 at BASE_ADDR+4 on the next cycle.
- JAL, rd=1, imm=3 → out_inst=32'h0000_0013, out_err=1. I_ALU, imm=2048 → same NOP/err. Address still advances by 4 for each.
- Backpressure: out_ready=0 for 5 cycles with continuous in_valid → exactly 2 bundles accepted, then in_ready=0 and outputs stable. On release, words emerge in order at BASE, +4, +8 with no loss or duplication.
- ADDR_W=4, BASE_ADDR=12: 2 words → addresses 12, then 0 (wrap).
- rst_n low while both stages are full → out_valid=0 immediately (asynchronously). After release, the first new word gets BASE_ADDR. A clear pulse behaves the same on the clock edge.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder: format enum,
// base opcodes, the canonical NOP and the per-format immediate range check.
package enc_pkg;

  typedef enum logic [2:0] {
    FMT_R      = 3'd0,
    FMT_I_LOAD = 3'd1,
    FMT_I_ALU  = 3'd2,
    FMT_S      = 3'd3,
    FMT_B      = 3'd4,
    FMT_JALR   = 3'd5,
    FMT_JAL    = 3'd6,
    FMT_ILL    = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // An immediate fits when every bit above the format's sign bit copies it;
  // B and JAL targets must also be halfword aligned.
  function automatic logic imm_fits(input fmt_e fmt, input logic [31:0] imm);
    logic ok;
    case (fmt)
      FMT_R:                                  ok = 1'b1;
      FMT_I_LOAD, FMT_I_ALU, FMT_S, FMT_JALR: ok = (&imm[31:11]) || !(|imm[31:11]);
      FMT_B:   ok = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
      FMT_JAL: ok = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/inst_encoder_imm_gen.sv
// Core immediate generator, used only by the round-trip self-check
// (INST_ENC_ROUNDTRIP_CHK_EN); decodes the sign-extended immediate of a word.
`ifdef INST_ENC_ROUNDTRIP_CHK_EN
module imm_Gen
  import enc_pkg::*;
(
  input  logic [31:0] inst,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (inst[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:  imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_JAL:    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:    imm = '0;
    endcase
  end

endmodule
`endif

// File: rtl/inst_encoder_pack.sv
// Combinational packer: places register, funct and immediate fields into the
// RV32I base instruction layouts. Only imm[20:0] can ever reach the word.
module enc_pack
  import enc_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [20:0] imm,
  output logic [31:0] inst
);

  always_comb begin
    // NOTE: default assignment first so every path drives inst and no latch is inferred.
    inst = NOP;
    case (fmt)
      FMT_R:      inst = {funct7, rs2, rs1, funct3, rd, OPC_R};
      FMT_I_LOAD: inst = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
      FMT_I_ALU:  inst = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
      FMT_S:      inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      FMT_B:      inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
      FMT_JALR:   inst = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
      FMT_JAL:    inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      default:    inst = NOP;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready RV32I instruction encoder tagging each word with a
// loader write address. INST_ENC_ROUNDTRIP_CHK_EN adds a decode self-check.
module inst_encoder
  import enc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  fmt_e              fmt,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
`ifdef INST_ENC_ROUNDTRIP_CHK_EN
  , output logic            rt_mismatch
`endif
);

  logic              s1_valid, s1_err;
  fmt_e              s1_fmt;
  logic [4:0]        s1_rd, s1_rs1, s1_rs2;
  logic [2:0]        s1_funct3;
  logic [6:0]        s1_funct7;
  logic [20:0]       s1_imm;
  logic              s2_valid, s2_err, s2_load;
  logic [31:0]       s2_inst, packed_inst;
  logic [ADDR_W-1:0] addr_q;

  assign s2_load  = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      s1_valid <= 1'b0;
    end else if (clear) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: payload flops are not reset; they are only observed behind s1_valid.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_fmt    <= fmt;
      s1_rd     <= rd;
      s1_rs1    <= rs1;
      s1_rs2    <= rs2;
      s1_funct3 <= funct3;
      s1_funct7 <= funct7;
      s1_imm    <= imm[20:0];
      s1_err    <= !imm_fits(fmt, imm);
    end
  end

  enc_pack u_pack (
    .fmt    (s1_fmt),
    .rd     (s1_rd),
    .rs1    (s1_rs1),
    .rs2    (s1_rs2),
    .funct3 (s1_funct3),
    .funct7 (s1_funct7),
    .imm    (s1_imm),
    .inst   (packed_inst)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_inst  <= '0;
      s2_err   <= 1'b0;
    end else if (clear) begin
      s2_valid <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_inst <= s1_err ? NOP : packed_inst;
        s2_err  <= s1_err;
      end
    end
  end

  // Errored words still occupy a slot, so every output handshake advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= BASE_ADDR;
    end else if (clear) begin
      addr_q <= BASE_ADDR;
    end else if (s2_valid && out_ready) begin
      addr_q <= addr_q + ADDR_W'(4);
    end
  end

  assign out_valid = s2_valid;
  assign out_inst  = s2_inst;
  assign out_err   = s2_err;
  assign out_addr  = addr_q;

`ifdef INST_ENC_ROUNDTRIP_CHK_EN
  fmt_e        s2_fmt;
  logic [20:0] s2_imm;
  logic [31:0] dec_imm;
  logic        rt_bad;

  always_ff @(posedge clk) begin
    if (s2_load && s1_valid) begin
      s2_fmt <= s1_fmt;
      s2_imm <= s1_imm;
    end
  end

  imm_Gen u_imm_gen (
    .inst (s2_inst),
    .imm  (dec_imm)
  );

  // Error-free words have imm[31:21] equal to imm[20], so the 21-bit copy suffices.
  assign rt_bad = s2_valid && !s2_err && (s2_fmt != FMT_R) && (s2_fmt != FMT_ILL)
                  && (dec_imm != {{11{s2_imm[20]}}, s2_imm});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rt_mismatch <= 1'b0;
    end else if (clear) begin
      rt_mismatch <= 1'b0;
    end else if (rt_bad) begin
      rt_mismatch <= 1'b1;
    end
  end

  a_roundtrip : assert property (@(posedge clk) disable iff (!rst_n) !rt_bad);
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: vector table plus hand-written sequences for
// latency, back-to-back, backpressure, address wrap, reset and clear.
module tb_inst_encoder;
  import enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  fmt_e        fmt = FMT_R;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;

  logic        in_ready, out_valid, out_err;
  logic [31:0] out_inst, out_addr;
  logic        in_ready2, out_valid2, out_err2;
  logic [31:0] out_inst2;
  logic [3:0]  out_addr2;
`ifdef INST_ENC_ROUNDTRIP_CHK_EN
  logic        rt1, rt2;
`endif

  inst_encoder dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .out_err(out_err)
`ifdef INST_ENC_ROUNDTRIP_CHK_EN
    , .rt_mismatch(rt1)
`endif
  );

  inst_encoder #(.ADDR_W(4), .BASE_ADDR(4'd12)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready2),
    .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid2), .out_ready(out_ready), .out_inst(out_inst2),
    .out_addr(out_addr2), .out_err(out_err2)
`ifdef INST_ENC_ROUNDTRIP_CHK_EN
    , .rt_mismatch(rt2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    fmt_e        fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  vec_t vt[16];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_k = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    fmt = v.fmt; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    funct3 = v.f3; funct7 = v.f7; imm = v.imm;
  endtask

  // Simple I_ALU bundle whose immediate tags the word's position in a stream.
  task automatic drive_tag(input int k);
    fmt = FMT_I_ALU; rd = 5'd1; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = k;
  endtask

  function automatic logic [31:0] tag_inst(input int k);
    return (32'(k) << 20) | 32'h0000_0093;
  endfunction

  function automatic logic [31:0] addr2_of(input int k);
    return 32'((12 + 4 * k) % 16);
  endfunction

  // One bundle in, one word out with out_ready held high; checks latency too.
  task automatic send_one(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    drive(v); in_valid = 1'b1; out_ready = 1'b1; #1;
    check({tag, " in_ready"}, in_ready, 1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; #1;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk); #1; lat++;
    end
    check({tag, " latency"}, lat, 2);
    check({tag, " inst"}, out_inst, v.inst);
    check({tag, " err"}, out_err, v.err);
    check({tag, " addr"}, out_addr, 32'(4 * exp_k));
    check({tag, " addr_w4"}, out_addr2, addr2_of(exp_k));
    exp_k++;
  endtask

  task automatic fill_both;
    @(negedge clk); out_ready = 1'b0; drive_tag(5); in_valid = 1'b1;
    @(posedge clk); @(negedge clk); drive_tag(6);
    @(posedge clk); @(negedge clk); in_valid = 1'b0; #1;
    check("fill out_valid", out_valid, 1);
    check("fill in_ready", in_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_n, n;
    logic acc;

    vt[0]  = '{FMT_I_ALU,  5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0};
    vt[1]  = '{FMT_S,      5'd9,  5'd3, 5'd2, 3'd2, 7'h00, 32'd8,         32'h0021_A423, 1'b0};
    vt[2]  = '{FMT_B,      5'd31, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0};
    vt[3]  = '{FMT_JAL,    5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'd3,         NOP,           1'b1};
    vt[4]  = '{FMT_I_ALU,  5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,      NOP,           1'b1};
    vt[5]  = '{FMT_R,      5'd3,  5'd1, 5'd2, 3'd0, 7'h20, 32'h1234_5678, 32'h4020_81B3, 1'b0};
    vt[6]  = '{FMT_I_LOAD, 5'd5,  5'd2, 5'd7, 3'd2, 7'h7F, 32'hFFFF_F800, 32'h8001_2283, 1'b0};
    vt[7]  = '{FMT_JALR,   5'd1,  5'd5, 5'd0, 3'd7, 7'h00, 32'd4,         32'h0042_80E7, 1'b0};
    vt[8]  = '{FMT_JAL,    5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h0010_00EF, 1'b0};
    vt[9]  = '{FMT_JAL,    5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFE, 32'hFFFF_F06F, 1'b0};
    vt[10] = '{FMT_B,      5'd0,  5'd0, 5'd0, 3'd1, 7'h00, 32'h0000_0FFE, 32'h7E00_1FE3, 1'b0};
    vt[11] = '{FMT_B,      5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_1000, NOP,           1'b1};
    vt[12] = '{FMT_B,      5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'd5,         NOP,           1'b1};
    vt[13] = '{FMT_ILL,    5'd1,  5'd1, 5'd1, 3'd0, 7'h00, 32'd0,         NOP,           1'b1};
    vt[14] = '{FMT_S,      5'd0,  5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFF_F7FF, NOP,           1'b1};
    vt[15] = '{FMT_JAL,    5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0000, NOP,           1'b1};

    // Reset state.
    #12;
    check("rst out_valid", out_valid, 0);
    check("rst out_inst", out_inst, 0);
    check("rst out_err", out_err, 0);
    check("rst out_addr", out_addr, 0);
    check("rst out_addr_w4", out_addr2, 12);
    @(negedge clk); rst_n = 1'b1;

    // Table: one word at a time, addresses advance even for errored words.
    for (int i = 0; i < 16; i++) send_one(vt[i], $sformatf("vec%0d", i));

    // Back-to-back S then B after a clear.
    @(negedge clk); clear = 1'b1; @(negedge clk); clear = 1'b0; exp_k = 0;
    drive(vt[1]); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk); drive(vt[2]);
    @(posedge clk); @(negedge clk); in_valid = 1'b0; #1;
    check("b2b first valid", out_valid, 1);
    check("b2b first inst", out_inst, 32'h0021_A423);
    check("b2b first addr", out_addr, 0);
    @(negedge clk); #1;
    check("b2b second valid", out_valid, 1);
    check("b2b second inst", out_inst, 32'hFE00_0EE3);
    check("b2b second addr", out_addr, 4);
    @(negedge clk); #1;
    check("b2b drained", out_valid, 0);

    // Backpressure: five stalled cycles with in_valid held high.
    @(negedge clk); clear = 1'b1; @(negedge clk); clear = 1'b0;
    out_ready = 1'b0; drive_tag(0); in_valid = 1'b1; acc_n = 0;
    for (int i = 0; i < 5; i++) begin
      #1; acc = in_ready;
      if (i >= 2) check("stall hold inst", out_inst, tag_inst(0));
      @(posedge clk); @(negedge clk);
      if (acc) begin acc_n++; drive_tag(acc_n); end
    end
    #1;
    check("stall accepted", acc_n, 2);
    check("stall in_ready", in_ready, 0);
    check("stall out_valid", out_valid, 1);
    check("stall addr", out_addr, 0);
    out_ready = 1'b1; n = 0;
    for (int c = 0; c < 10; c++) begin
      #1; acc = in_valid && in_ready;
      if (out_valid) begin
        check($sformatf("drain%0d inst", n), out_inst, tag_inst(n));
        check($sformatf("drain%0d addr", n), out_addr, 32'(4 * n));
        check($sformatf("drain%0d addr_w4", n), out_addr2, addr2_of(n));
        n++;
      end
      @(posedge clk); @(negedge clk);
      if (acc) in_valid = 1'b0;
    end
    check("drain count", n, 3);

    // Asynchronous reset with both stages full.
    fill_both;
    #2 rst_n = 1'b0; #1;
    check("async rst out_valid", out_valid, 0);
    check("async rst out_inst", out_inst, 0);
    check("async rst out_valid_w4", out_valid2, 0);
    @(negedge clk); rst_n = 1'b1; exp_k = 0;
    send_one(vt[0], "post_rst");

    // Clear with both stages full and a handshake offered the same cycle.
    fill_both;
    @(negedge clk); out_ready = 1'b1; clear = 1'b1;
    @(posedge clk); @(negedge clk); clear = 1'b0; #1;
    check("clear out_valid", out_valid, 0);
    check("clear in_ready", in_ready, 1);
    exp_k = 0;
    send_one(vt[1], "post_clear");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
